tx_fifo: RTL and testbench

- Transmit FIFO that sits directly upstream of the SSP transmit logic.
- Accepts parallel bytes from the processor bus (PSEL/PWRITE/PWDATA) and presents the oldest byte show-ahead on TxData.
- Pops one byte per read_fifo strobe from the transmit logic.
- Flags empty and full; full drives SSPTXINTR.

---
 rtl/tx_fifo_if.sv | 27 ++
 rtl/tx_fifo.sv | 87 ++++++++
 tb/tb_tx_fifo.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/tx_fifo_if.sv
// Bus bundle between the processor-side writer / SSP transmit logic and tx_fifo.
// The master drives push/pop requests; the slave (the FIFO) returns head data and status.
interface tx_fifo_if #(
  parameter int WIDTH = 8,
  parameter int PTR_W = 2
);
  logic             PSEL;
  logic             PWRITE;
  logic [WIDTH-1:0] PWDATA;
  logic             read_fifo;
  logic [WIDTH-1:0] TxData;
  logic             tx_fifo_empty;
  logic             SSPTXINTR;
  logic [PTR_W:0]   fill_count;
  logic             overflow_err;
  logic             underflow_err;

  modport master (
    output PSEL, PWRITE, PWDATA, read_fifo,
    input  TxData, tx_fifo_empty, SSPTXINTR, fill_count, overflow_err, underflow_err
  );

  modport slave (
    input  PSEL, PWRITE, PWDATA, read_fifo,
    output TxData, tx_fifo_empty, SSPTXINTR, fill_count, overflow_err, underflow_err
  );
endinterface

// File: rtl/tx_fifo.sv
// Show-ahead transmit FIFO: a write appears on TxData/flags 1 cycle later; a pop edge advances the head in 1 cycle.
// Backpressure: writes when full are dropped (sticky overflow_err) unless a pop lands on the same edge.
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic      PCLK,
  input logic      CLEAR,
  tx_fifo_if.slave bus
);

  localparam logic [PTR_W:0] LP_DEPTH = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_empty;
  logic             r_full;
  logic             r_ovf;
  logic             r_unf;
  logic             r_rd_q;

  logic             w_wr_req;
  logic             w_rd_req;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [PTR_W:0]   w_count_nxt;

  // read_fifo may be held high; only its rising edge counts as a pop
  assign w_wr_req  = bus.PSEL & bus.PWRITE;
  assign w_rd_req  = bus.read_fifo & ~r_rd_q;
  assign w_push_ok = w_wr_req & (~r_full | w_rd_req);
  assign w_pop_ok  = w_rd_req & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push_ok && w_pop_ok) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_rd_q   <= 1'b0;
    end else begin
      r_rd_q <= bus.read_fifo;
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= bus.PWDATA;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == LP_DEPTH);
      if (w_wr_req && !w_push_ok) begin
        r_ovf <= 1'b1;
      end
      if (w_rd_req && r_empty) begin
        r_unf <= 1'b1;
      end
    end
  end

  assign bus.TxData        = r_mem[r_rd_ptr];
  assign bus.tx_fifo_empty = r_empty;
  assign bus.SSPTXINTR     = r_full;
  assign bus.fill_count    = r_count;
  assign bus.overflow_err  = r_ovf;
  assign bus.underflow_err = r_unf;

endmodule

// File: tb/tb_tx_fifo.sv
// Bench for tx_fifo: directed scenarios plus random traffic against a queue-based model,
// with a separate monitor that checks every popped byte against a scoreboard queue.
module tb_tx_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic PCLK;
  logic CLEAR;

  tx_fifo_if #(.WIDTH(WIDTH), .PTR_W(PTR_W)) bus ();

  tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .PCLK  (PCLK),
    .CLEAR (CLEAR),
    .bus   (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mq[$];   // model contents, oldest first
  logic [7:0] sb[$];   // bytes expected to leave the FIFO, in order
  bit         m_ovf, m_unf, m_prev;
  bit         mon_prev;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: a rising read_fifo while data is present hands out TxData
  initial begin
    mon_prev = 1'b0;
    forever begin
      @(negedge PCLK);
      if (CLEAR) begin
        mon_prev = 1'b0;
      end else begin
        if (bus.read_fifo && !mon_prev && !bus.tx_fifo_empty) begin
          if (sb.size() == 0) begin
            chk("pop_unexpected", 32'd1, 32'd0);
          end else begin
            chk("pop_data", 32'(bus.TxData), 32'(sb.pop_front()));
          end
        end
        mon_prev = bus.read_fifo;
      end
    end
  end

  task automatic check_state();
    chk("fill_count", 32'(bus.fill_count), 32'(mq.size()));
    chk("empty", 32'(bus.tx_fifo_empty), 32'(mq.size() == 0));
    chk("full", 32'(bus.SSPTXINTR), 32'(mq.size() == DEPTH));
    chk("overflow_err", 32'(bus.overflow_err), 32'(m_ovf));
    chk("underflow_err", 32'(bus.underflow_err), 32'(m_unf));
    if (mq.size() > 0) chk("head", 32'(bus.TxData), 32'(mq[0]));
  endtask

  // Called at posedge+1: drive one cycle, advance the model, check after the edge
  task automatic step(input bit ps, input bit pw, input logic [7:0] d, input bit rf);
    bit rdr, wr, pop, push;
    int sz;
    bus.PSEL = ps; bus.PWRITE = pw; bus.PWDATA = d; bus.read_fifo = rf;
    wr   = ps && pw;
    rdr  = rf && !m_prev;
    sz   = mq.size();
    pop  = rdr && (sz > 0);
    push = wr && ((sz < DEPTH) || rdr);
    if (wr && !push) m_ovf = 1'b1;
    if (rdr && sz == 0) m_unf = 1'b1;
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back(d);
      sb.push_back(d);
    end
    m_prev = rf;
    @(posedge PCLK);
    #1;
    check_state();
  endtask

  task automatic clear_async();
    #2;
    CLEAR = 1'b1;
    #1;
    chk("rst_fill", 32'(bus.fill_count), 32'd0);
    chk("rst_empty", 32'(bus.tx_fifo_empty), 32'd1);
    chk("rst_full", 32'(bus.SSPTXINTR), 32'd0);
    chk("rst_txdata", 32'(bus.TxData), 32'h00);
    chk("rst_ovf", 32'(bus.overflow_err), 32'd0);
    chk("rst_unf", 32'(bus.underflow_err), 32'd0);
    mq.delete(); sb.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_prev = 1'b0;
    bus.PSEL = 1'b0; bus.PWRITE = 1'b0; bus.PWDATA = '0; bus.read_fifo = 1'b0;
    @(posedge PCLK);
    #1;
    CLEAR = 1'b0;
  endtask

  task automatic pop_n(input int n);
    for (int k = 0; k < n; k++) begin
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 0);
    end
  endtask

  initial begin
    CLEAR = 1'b1;
    bus.PSEL = 1'b0; bus.PWRITE = 1'b0; bus.PWDATA = '0; bus.read_fifo = 1'b0;
    @(posedge PCLK);
    #1;
    clear_async();
    step(0, 0, 8'h00, 0);

    // single byte, then a held read_fifo gives one pop only
    step(1, 1, 8'hA5, 0);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    // fill, overflow, drain in order
    step(1, 1, 8'h11, 0);
    step(1, 1, 8'h22, 0);
    step(1, 1, 8'h33, 0);
    step(1, 1, 8'h44, 0);
    step(1, 1, 8'h55, 0);
    pop_n(4);

    // full with simultaneous push and pop edge
    clear_async();
    step(1, 1, 8'h11, 0);
    step(1, 1, 8'h22, 0);
    step(1, 1, 8'h33, 0);
    step(1, 1, 8'h44, 0);
    step(1, 1, 8'h66, 1);
    step(0, 0, 8'h00, 0);
    pop_n(4);

    // pointer wrap with alternating write/pop
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 8'(i), 0);
      step(0, 0, 8'h00, 1);
    end
    step(0, 0, 8'h00, 0);

    // pops on empty, push+pop on empty, then async clear with 3 queued
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);
    step(1, 1, 8'h77, 1);
    step(1, 1, 8'h78, 0);
    step(1, 1, 8'h79, 0);
    clear_async();
    step(0, 0, 8'h00, 0);

    // random traffic: write-heavy then read-heavy, with one mid-stream clear
    for (int i = 0; i < 600; i++) begin
      bit ps, pw, rf;
      if (i == 300) clear_async();
      ps = ($urandom_range(0, 9) < ((i % 200) < 100 ? 7 : 3));
      pw = ($urandom_range(0, 7) != 0);
      rf = ($urandom_range(0, 1) == 1);
      step(ps, pw, 8'($urandom), rf);
    end

    step(0, 0, 8'h00, 0);
    pop_n(DEPTH + 1);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
